// File: rtl/motor_duty_sched.sv
// motor_duty_sched
//
// Schedules duty-cycle updates for the left and right PWM generators of the
// drive stage. Duty commands arrive over a valid/ready handshake. They take
// effect only at PWM period boundaries, signalled by i_period_end.
// When enable is lost, both channels are ramped down to zero.
//
// Optional feature macro: MOTOR_DUTY_SLEW_EN
//   defined   : each channel moves at most STEP per PWM period
//   undefined : each channel jumps straight to its target at the next period end
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_en          drive enable; low forces a ramp-down to zero
//   i_period_end  one-cycle pulse when the PWM counter is all-ones
//   i_cmd_vld     new duty command present
//   o_cmd_rdy     command can be accepted this cycle (combinational)
//   i_cmd_lft     requested left duty
//   i_cmd_rght    requested right duty
//   o_lft_duty    registered left duty to PWM
//   o_rght_duty   registered right duty to PWM
//   o_duty_upd    one-cycle pulse after a period end that changed a duty
//   o_busy        high while ramping (RAMP) or ramping down (STOP)

module motor_duty_sched #(
    parameter int                DUTY_W   = 14,
    parameter logic [DUTY_W-1:0] STEP     = 14'd64,
    parameter logic [DUTY_W-1:0] MAX_DUTY = 14'h3FF0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_period_end,
    input  logic              i_cmd_vld,
    output logic              o_cmd_rdy,
    input  logic [DUTY_W-1:0] i_cmd_lft,
    input  logic [DUTY_W-1:0] i_cmd_rght,
    output logic [DUTY_W-1:0] o_lft_duty,
    output logic [DUTY_W-1:0] o_rght_duty,
    output logic              o_duty_upd,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } stateT;

`ifdef MOTOR_DUTY_SLEW_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif

    // Without slewing, the step limit is larger than any possible difference.
    // Every move then lands directly on the target.
    localparam logic [DUTY_W:0] STEP_LIMIT = SLEW_ON ? {1'b0, STEP} : '1;

    stateT             r_state;
    logic [DUTY_W-1:0] r_lftTgt;
    logic [DUTY_W-1:0] r_rghtTgt;
    logic [DUTY_W-1:0] r_lftDuty;
    logic [DUTY_W-1:0] r_rghtDuty;
    logic              r_dutyUpd;

    logic              w_accept;
    logic [DUTY_W-1:0] w_lftSat;
    logic [DUTY_W-1:0] w_rghtSat;
    logic [DUTY_W-1:0] w_lftNext;
    logic [DUTY_W-1:0] w_rghtNext;
    logic              w_atTarget;

    // Moves cur one step toward tgt.
    // The difference is taken one bit wider, so it can never wrap.
    // Adding or subtracting STEP happens only when the gap exceeds STEP.
    // The result therefore never passes the target or goes below zero.
    function automatic logic [DUTY_W-1:0] stepToward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt
    );
        logic [DUTY_W:0] diff;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            stepToward = (diff <= STEP_LIMIT) ? tgt : cur + STEP;
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
            stepToward = (diff <= STEP_LIMIT) ? tgt : cur - STEP;
        end
    endfunction

    assign o_cmd_rdy  = i_en && ((r_state == IDLE) || (r_state == HOLD));
    assign w_accept   = i_cmd_vld && o_cmd_rdy;
    assign w_lftSat   = (i_cmd_lft  > MAX_DUTY) ? MAX_DUTY : i_cmd_lft;
    assign w_rghtSat  = (i_cmd_rght > MAX_DUTY) ? MAX_DUTY : i_cmd_rght;
    assign w_lftNext  = stepToward(r_lftDuty,  r_lftTgt);
    assign w_rghtNext = stepToward(r_rghtDuty, r_rghtTgt);
    assign w_atTarget = (r_lftDuty == r_lftTgt) && (r_rghtDuty == r_rghtTgt);

    assign o_lft_duty  = r_lftDuty;
    assign o_rght_duty = r_rghtDuty;
    assign o_duty_upd  = r_dutyUpd;
    assign o_busy      = (r_state == RAMP) || (r_state == STOP);

    // Scheduler state machine.
    // Duties change only on a period end while in RAMP or STOP.
    // A period end that finds both channels already on target ends the ramp
    // and leaves the outputs unchanged.
    // In HOLD, an accept coinciding with a period end does not step.
    // The new target is first used at the following period end.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_lftTgt   <= '0;
            r_rghtTgt  <= '0;
            r_lftDuty  <= '0;
            r_rghtDuty <= '0;
            r_dutyUpd  <= 1'b0;
        end else begin
            r_dutyUpd <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_lftTgt  <= w_lftSat;
                        r_rghtTgt <= w_rghtSat;
                        r_state   <= RAMP;
                    end
                end
                RAMP, HOLD: begin
                    if (!i_en) begin
                        r_lftTgt  <= '0;
                        r_rghtTgt <= '0;
                        r_state   <= STOP;
                    end else begin
                        if (i_period_end && (r_state == RAMP)) begin
                            if (w_atTarget) begin
                                r_state <= HOLD;
                            end else begin
                                r_lftDuty  <= w_lftNext;
                                r_rghtDuty <= w_rghtNext;
                                r_dutyUpd  <= 1'b1;
                            end
                        end
                        if (w_accept) begin
                            r_lftTgt  <= w_lftSat;
                            r_rghtTgt <= w_rghtSat;
                            r_state   <= RAMP;
                        end
                    end
                end
                STOP: begin
                    // The targets are already zero here.
                    // The block leaves STOP only through IDLE, whatever i_en does.
                    if (i_period_end) begin
                        if (w_atTarget) begin
                            r_state <= IDLE;
                        end else begin
                            r_lftDuty  <= w_lftNext;
                            r_rghtDuty <= w_rghtNext;
                            r_dutyUpd  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_duty_sched.sv
// tb_motor_duty_sched
//
// Directed bench for motor_duty_sched.
// Expected duty sequences follow MOTOR_DUTY_SLEW_EN, matching the build
// of the design.
// Period-end pulses are issued one at a time, so PWM periods are short.

module tb_motor_duty_sched;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic        i_period_end;
    logic        i_cmd_vld;
    logic        o_cmd_rdy;
    logic [13:0] i_cmd_lft;
    logic [13:0] i_cmd_rght;
    logic [13:0] o_lft_duty;
    logic [13:0] o_rght_duty;
    logic        o_duty_upd;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    bit sawOverflow = 1'b0;

    motor_duty_sched dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_period_end (i_period_end),
        .i_cmd_vld    (i_cmd_vld),
        .o_cmd_rdy    (o_cmd_rdy),
        .i_cmd_lft    (i_cmd_lft),
        .i_cmd_rght   (i_cmd_rght),
        .o_lft_duty   (o_lft_duty),
        .o_rght_duty  (o_rght_duty),
        .o_duty_upd   (o_duty_upd),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // A saturated command must never let the raw 0x3FFF through to the PWM.
    always @(posedge i_clk) begin
        if (o_lft_duty == 14'h3FFF || o_rght_duty == 14'h3FFF)
            sawOverflow = 1'b1;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of command and period-end inputs, then releases them.
    task automatic applyStimulus(input logic vld, input logic [13:0] lft,
                                 input logic [13:0] rght, input logic pe);
        i_cmd_vld    = vld;
        i_cmd_lft    = lft;
        i_cmd_rght   = rght;
        i_period_end = pe;
        tick();
        i_cmd_vld    = 1'b0;
        i_period_end = 1'b0;
    endtask

    task automatic pulsePe();
        i_period_end = 1'b1;
        tick();
        i_period_end = 1'b0;
    endtask

    // Issues period ends until busy drops.
    // Running out of budget is recorded as a failure.
    task automatic waitIdleOrHold(input string tag, input int maxPe);
        int n = 0;
        do begin
            pulsePe();
            tick();
            n++;
        end while (o_busy && n < maxPe);
        checkOutput(tag, {15'd0, o_busy}, 16'h0);
    endtask

    logic [13:0] expL[$];
    logic [13:0] expR[$];
    logic        expU[$];
    logic        expB[$];

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_period_end = 1'b0; i_cmd_vld = 1'b0;
        i_cmd_lft = '0; i_cmd_rght = '0;
        tick(); tick(); tick();
        checkOutput("rst_lft",  {2'b0, o_lft_duty},  16'h0);
        checkOutput("rst_rght", {2'b0, o_rght_duty}, 16'h0);
        checkOutput("rst_upd",  {15'd0, o_duty_upd}, 16'h0);
        checkOutput("rst_busy", {15'd0, o_busy},     16'h0);
        checkOutput("rst_rdy",  {15'd0, o_cmd_rdy},  16'h0);
        i_rst = 1'b0;
        tick();
        i_en = 1'b1;
        #1;
        checkOutput("rdy_en", {15'd0, o_cmd_rdy}, 16'h1);

        // Ramp up from zero.
        applyStimulus(1'b1, 14'h0100, 14'h0080, 1'b0);
        checkOutput("acc_busy", {15'd0, o_busy},    16'h1);
        checkOutput("acc_rdy",  {15'd0, o_cmd_rdy}, 16'h0);
        checkOutput("acc_lft",  {2'b0, o_lft_duty}, 16'h0);
`ifdef MOTOR_DUTY_SLEW_EN
        expL = '{14'h040, 14'h080, 14'h0C0, 14'h100, 14'h100};
        expR = '{14'h040, 14'h080, 14'h080, 14'h080, 14'h080};
        expU = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        expB = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
        expL = '{14'h100, 14'h100};
        expR = '{14'h080, 14'h080};
        expU = '{1'b1, 1'b0};
        expB = '{1'b1, 1'b0};
`endif
        for (int i = 0; i < expL.size(); i++) begin
            pulsePe();
            checkOutput($sformatf("up_lft%0d", i),  {2'b0, o_lft_duty},  {2'b0, expL[i]});
            checkOutput($sformatf("up_rght%0d", i), {2'b0, o_rght_duty}, {2'b0, expR[i]});
            checkOutput($sformatf("up_upd%0d", i),  {15'd0, o_duty_upd}, {15'd0, expU[i]});
            checkOutput($sformatf("up_busy%0d", i), {15'd0, o_busy},     {15'd0, expB[i]});
            tick();
            checkOutput($sformatf("up_updoff%0d", i), {15'd0, o_duty_upd}, 16'h0);
        end
        checkOutput("hold_rdy", {15'd0, o_cmd_rdy}, 16'h1);

        // Accept on the same cycle as a period end while in HOLD.
        applyStimulus(1'b1, 14'h0200, 14'h0080, 1'b1);
        checkOutput("coin_lft",  {2'b0, o_lft_duty},  16'h0100);
        checkOutput("coin_upd",  {15'd0, o_duty_upd}, 16'h0);
        checkOutput("coin_busy", {15'd0, o_busy},     16'h1);
        pulsePe();
`ifdef MOTOR_DUTY_SLEW_EN
        checkOutput("coin_next", {2'b0, o_lft_duty}, 16'h0140);
`else
        checkOutput("coin_next", {2'b0, o_lft_duty}, 16'h0200);
`endif
        tick();
        waitIdleOrHold("coin_hold", 20);
        checkOutput("coin_final", {2'b0, o_lft_duty},  16'h0200);
        checkOutput("coin_rght",  {2'b0, o_rght_duty}, 16'h0080);

        // Settle at 0xA0, then drop enable while a command is offered.
        applyStimulus(1'b1, 14'h00A0, 14'h00A0, 1'b0);
        waitIdleOrHold("a0_hold", 20);
        checkOutput("a0_lft", {2'b0, o_lft_duty}, 16'h00A0);
        i_en = 1'b0;
        applyStimulus(1'b1, 14'h3000, 14'h3000, 1'b0);
        checkOutput("stop_busy", {15'd0, o_busy},     16'h1);
        checkOutput("stop_rdy",  {15'd0, o_cmd_rdy},  16'h0);
        checkOutput("stop_lft",  {2'b0, o_lft_duty},  16'h00A0);
`ifdef MOTOR_DUTY_SLEW_EN
        expL = '{14'h060, 14'h020, 14'h000};
`else
        expL = '{14'h000};
`endif
        for (int i = 0; i < expL.size(); i++) begin
            pulsePe();
            checkOutput($sformatf("dn_lft%0d", i),  {2'b0, o_lft_duty},  {2'b0, expL[i]});
            checkOutput($sformatf("dn_rght%0d", i), {2'b0, o_rght_duty}, {2'b0, expL[i]});
            checkOutput($sformatf("dn_upd%0d", i),  {15'd0, o_duty_upd}, 16'h1);
            if (i == 0) begin
                // Enable returning during STOP must not reopen the handshake.
                i_en = 1'b1;
                applyStimulus(1'b1, 14'h3000, 14'h3000, 1'b0);
                checkOutput("stop_en_busy", {15'd0, o_busy},    16'h1);
                checkOutput("stop_en_rdy",  {15'd0, o_cmd_rdy}, 16'h0);
            end
        end
        pulsePe();
        checkOutput("idle_busy", {15'd0, o_busy},     16'h0);
        checkOutput("idle_upd",  {15'd0, o_duty_upd}, 16'h0);
        checkOutput("idle_rdy",  {15'd0, o_cmd_rdy},  16'h1);

        // Saturation of an oversize command.
        applyStimulus(1'b1, 14'h3FFF, 14'h3FFF, 1'b0);
        waitIdleOrHold("sat_hold", 300);
        checkOutput("sat_lft",  {2'b0, o_lft_duty},  16'h3FF0);
        checkOutput("sat_rght", {2'b0, o_rght_duty}, 16'h3FF0);
        checkOutput("sat_never", {15'd0, sawOverflow}, 16'h0);

        // Reset in the middle of a ramp.
        applyStimulus(1'b1, 14'h0400, 14'h0400, 1'b0);
        pulsePe();
`ifdef MOTOR_DUTY_SLEW_EN
        checkOutput("mid_lft", {2'b0, o_lft_duty}, 16'h3FB0);
`else
        checkOutput("mid_lft", {2'b0, o_lft_duty}, 16'h0400);
`endif
        i_rst = 1'b1;
        tick();
        checkOutput("mrst_lft",  {2'b0, o_lft_duty},  16'h0);
        checkOutput("mrst_rght", {2'b0, o_rght_duty}, 16'h0);
        checkOutput("mrst_busy", {15'd0, o_busy},     16'h0);
        checkOutput("mrst_upd",  {15'd0, o_duty_upd}, 16'h0);
        i_rst = 1'b0;
        pulsePe();
        checkOutput("mrst_keep", {2'b0, o_lft_duty}, 16'h0);
        checkOutput("mrst_idle", {15'd0, o_busy},    16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
